// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl
// Description : Valid/allowin handshake control for a 5-stage in-order
//               pipeline with load-to-use stall, branch redirect and a
//               saturating stall-cycle counter.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl (
    input  logic        clk,
    input  logic        resetn,
    input  logic        in_valid,
    input  logic [4:0]  ready_go,
    input  logic        hazard_stall,
    input  logic        redirect,
    output logic [4:0]  stage_valid,
    output logic [4:0]  stage_allowin,
    output logic [4:0]  stage_en,
    output logic        in_allowin,
    output logic [15:0] stall_cnt
);

    localparam int          NUM_STAGES = 5;
    localparam logic [15:0] c_CNT_MAX  = 16'hFFFF;

    logic [4:0]  r_stage_valid;
    logic [15:0] r_stall_cnt;

    logic [4:0]  w_rg;
    logic [4:0]  w_fwd;
    logic [4:0]  w_src;
    logic [4:0]  w_allowin;
    logic        w_stall_inc;

    // Only ID sees the hazard; it holds its instruction in place.
    always_comb begin
        w_rg    = ready_go;
        w_rg[1] = ready_go[1] & ~hazard_stall;
        w_fwd   = r_stage_valid & w_rg;
    end

    // Allowin ripples from WB back toward IF; no path runs the other way.
    always_comb begin
        w_allowin    = '0;
        w_allowin[4] = ~r_stage_valid[4] | w_rg[4];
        for (int i = NUM_STAGES - 2; i >= 0; i--) begin
            w_allowin[i] = ~r_stage_valid[i] | (w_rg[i] & w_allowin[i+1]);
        end
    end

    // A taken branch in EX blocks both the new fetch and the ID->EX transfer.
    always_comb begin
        w_src    = '0;
        w_src[0] = in_valid & ~redirect;
        w_src[1] = w_fwd[0];
        w_src[2] = w_fwd[1] & ~redirect;
        w_src[3] = w_fwd[2];
        w_src[4] = w_fwd[3];
    end

    assign w_stall_inc = r_stage_valid[1] & hazard_stall & ~redirect;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_stage_valid <= '0;
            r_stall_cnt   <= '0;
        end else begin
            for (int i = 0; i < NUM_STAGES; i++) begin
                if (w_allowin[i]) begin
                    r_stage_valid[i] <= w_src[i];
                end
            end
            if (redirect) begin
                r_stage_valid[0] <= 1'b0;
                r_stage_valid[1] <= 1'b0;
            end
            if (w_stall_inc && (r_stall_cnt != c_CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
        end
    end

    assign stage_valid   = r_stage_valid;
    assign stage_allowin = w_allowin;
    assign stage_en      = w_allowin & w_src;
    assign in_allowin    = w_allowin[0] & ~redirect;
    assign stall_cnt     = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_ctrl
// Description : Directed self-checking bench for pipe_ctrl; expected stage
//               state is queued at drive time and checked after each edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl;

    logic        clk;
    logic        resetn;
    logic        in_valid;
    logic [4:0]  ready_go;
    logic        hazard_stall;
    logic        redirect;
    logic [4:0]  stage_valid;
    logic [4:0]  stage_allowin;
    logic [4:0]  stage_en;
    logic        in_allowin;
    logic [15:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [4:0]  valid;
        logic [15:0] cnt;
    } exp_t;

    exp_t exp_q[$];

    pipe_ctrl dut (
        .clk          (clk),
        .resetn       (resetn),
        .in_valid     (in_valid),
        .ready_go     (ready_go),
        .hazard_stall (hazard_stall),
        .redirect     (redirect),
        .stage_valid  (stage_valid),
        .stage_allowin(stage_allowin),
        .stage_en     (stage_en),
        .in_allowin   (in_allowin),
        .stall_cnt    (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs and queue the state expected after the edge.
    task automatic drive(input string tag, input logic iv, input logic [4:0] rgo,
                         input logic hz, input logic rd,
                         input logic [4:0] exp_valid, input logic [15:0] exp_cnt);
        exp_t e;
        in_valid     = iv;
        ready_go     = rgo;
        hazard_stall = hz;
        redirect     = rd;
        e.tag   = tag;
        e.valid = exp_valid;
        e.cnt   = exp_cnt;
        exp_q.push_back(e);
        #1;
    endtask

    task automatic comb(input string tag, input logic [4:0] exp_allowin,
                        input logic [4:0] exp_en, input logic exp_in_allowin);
        chk({tag, "_allowin"}, {11'd0, stage_allowin}, {11'd0, exp_allowin});
        chk({tag, "_en"}, {11'd0, stage_en}, {11'd0, exp_en});
        chk({tag, "_in_allowin"}, {15'd0, in_allowin}, {15'd0, exp_in_allowin});
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk("queue_underflow", 16'd1, 16'd0);
        end else begin
            e = exp_q.pop_front();
            chk({e.tag, "_valid"}, {11'd0, stage_valid}, {11'd0, e.valid});
            chk({e.tag, "_cnt"}, stall_cnt, e.cnt);
        end
    endtask

    task automatic step(input string tag, input logic iv, input logic [4:0] rgo,
                        input logic hz, input logic rd,
                        input logic [4:0] exp_valid, input logic [15:0] exp_cnt);
        drive(tag, iv, rgo, hz, rd, exp_valid, exp_cnt);
        tick();
    endtask

    initial begin
        logic [4:0] fill;
        resetn       = 1'b0;
        in_valid     = 1'b0;
        ready_go     = 5'b00000;
        hazard_stall = 1'b0;
        redirect     = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state and combinational outputs while held in reset
        chk("reset_valid", {11'd0, stage_valid}, 16'd0);
        chk("reset_cnt", stall_cnt, 16'd0);
        chk("reset_allowin", {11'd0, stage_allowin}, 16'h001F);
        resetn = 1'b1;

        // Free flow fill
        drive("flow1", 1'b1, 5'b11111, 1'b0, 1'b0, 5'b00001, 16'd0);
        comb("flow1", 5'b11111, 5'b00001, 1'b1);
        tick();
        step("flow2", 1'b1, 5'b11111, 1'b0, 1'b0, 5'b00011, 16'd0);
        step("flow3", 1'b1, 5'b11111, 1'b0, 1'b0, 5'b00111, 16'd0);
        step("flow4", 1'b1, 5'b11111, 1'b0, 1'b0, 5'b01111, 16'd0);
        step("flow5", 1'b1, 5'b11111, 1'b0, 1'b0, 5'b11111, 16'd0);

        // Load-to-use stall, two cycles, then recover
        drive("luse1", 1'b1, 5'b11111, 1'b1, 1'b0, 5'b11011, 16'd1);
        comb("luse1", 5'b11100, 5'b11000, 1'b0);
        tick();
        drive("luse2", 1'b1, 5'b11111, 1'b1, 1'b0, 5'b10011, 16'd2);
        comb("luse2", 5'b11100, 5'b10000, 1'b0);
        tick();
        step("luse3", 1'b1, 5'b11111, 1'b0, 1'b0, 5'b00111, 16'd2);
        step("luse4", 1'b1, 5'b11111, 1'b0, 1'b0, 5'b01111, 16'd2);
        step("luse5", 1'b1, 5'b11111, 1'b0, 1'b0, 5'b11111, 16'd2);

        // Back-pressure from MEM: WB empties, everything upstream holds
        drive("bp1", 1'b1, 5'b10111, 1'b0, 1'b0, 5'b01111, 16'd2);
        comb("bp1", 5'b10000, 5'b00000, 1'b0);
        tick();
        drive("bp2", 1'b1, 5'b10111, 1'b0, 1'b0, 5'b01111, 16'd2);
        comb("bp2", 5'b10000, 5'b00000, 1'b0);
        tick();
        step("bp3", 1'b1, 5'b10111, 1'b0, 1'b0, 5'b01111, 16'd2);

        // Release with no new input: held instructions drain one stage per cycle
        fill = 5'b01111;
        for (int i = 0; i < 5; i++) begin
            fill = fill << 1;
            step("drain", 1'b0, 5'b11111, 1'b0, 1'b0, fill, 16'd2);
        end

        // Refill
        fill = 5'b00000;
        for (int i = 0; i < 5; i++) begin
            fill = {fill[3:0], 1'b1};
            step("refill", 1'b1, 5'b11111, 1'b0, 1'b0, fill, 16'd2);
        end

        // Redirect pulse on a full pipe
        drive("redir", 1'b1, 5'b11111, 1'b0, 1'b1, 5'b11000, 16'd2);
        comb("redir", 5'b11111, 5'b11010, 1'b0);
        tick();
        step("redir_r1", 1'b1, 5'b11111, 1'b0, 1'b0, 5'b10001, 16'd2);
        step("redir_r2", 1'b1, 5'b11111, 1'b0, 1'b0, 5'b00011, 16'd2);
        step("redir_r3", 1'b1, 5'b11111, 1'b0, 1'b0, 5'b00111, 16'd2);
        step("redir_r4", 1'b1, 5'b11111, 1'b0, 1'b0, 5'b01111, 16'd2);
        step("redir_r5", 1'b1, 5'b11111, 1'b0, 1'b0, 5'b11111, 16'd2);

        // Redirect and hazard together: redirect wins, no stall counted
        drive("redir_hz", 1'b1, 5'b11111, 1'b1, 1'b1, 5'b11000, 16'd2);
        comb("redir_hz", 5'b11100, 5'b11000, 1'b0);
        tick();
        step("rhz_r1", 1'b1, 5'b11111, 1'b0, 1'b0, 5'b10001, 16'd2);
        step("rhz_r2", 1'b1, 5'b11111, 1'b0, 1'b0, 5'b00011, 16'd2);

        // Long hazard: ID stays occupied so every cycle counts
        in_valid     = 1'b1;
        ready_go     = 5'b11111;
        hazard_stall = 1'b1;
        redirect     = 1'b0;
        for (int i = 0; i < 65532; i++) @(posedge clk);
        #1;
        chk("preload_cnt", stall_cnt, 16'hFFFE);
        step("sat1", 1'b1, 5'b11111, 1'b1, 1'b0, 5'b00011, 16'hFFFF);
        step("sat2", 1'b1, 5'b11111, 1'b1, 1'b0, 5'b00011, 16'hFFFF);
        step("sat3", 1'b1, 5'b11111, 1'b1, 1'b0, 5'b00011, 16'hFFFF);

        // Mid-operation reset for a single edge
        resetn = 1'b0;
        step("midrst", 1'b1, 5'b11111, 1'b1, 1'b0, 5'b00000, 16'd0);
        chk("midrst_allowin", {11'd0, stage_allowin}, 16'h001F);
        resetn = 1'b1;

        // Hazard with empty ID has no effect
        step("hz_empty1", 1'b0, 5'b11111, 1'b1, 1'b0, 5'b00000, 16'd0);
        step("hz_empty2", 1'b1, 5'b11111, 1'b1, 1'b0, 5'b00001, 16'd0);

        chk("queue_empty", 16'(exp_q.size()), 16'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
